// File: rtl/risc_v_cpu_core.sv
// Single-cycle RV32I core: combinational fetch/decode/execute with PC, register
// file, data-memory stores and the writeback debug value all committed on one edge.

module rv_instruction_memory #(
  parameter int BYTES = 1024
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);
  localparam int AW = $clog2(BYTES);
  localparam logic [31:0] BYTES_W = 32'(BYTES);

  logic [7:0]    memory [0:BYTES-1];
  logic [31:0]   base;
  logic [AW-1:0] idx [0:3];

  // Contents are preloaded from outside the design, so there is no write path.
  always_comb begin
    base = addr % BYTES_W;
    for (int k = 0; k < 4; k++) idx[k] = AW'((base + 32'(k)) % BYTES_W);
    instr = {memory[idx[3]], memory[idx[2]], memory[idx[1]], memory[idx[0]]};
  end
endmodule

module rv_data_memory #(
  parameter int BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(BYTES);
  localparam logic [31:0] BYTES_W = 32'(BYTES);

  logic [7:0]    memory [0:BYTES-1];
  logic [31:0]   base;
  logic [AW-1:0] idx [0:3];

  always_comb begin
    base = addr % BYTES_W;
    for (int k = 0; k < 4; k++) idx[k] = AW'((base + 32'(k)) % BYTES_W);
    rdata = {memory[idx[3]], memory[idx[2]], memory[idx[1]], memory[idx[0]]};
  end

  // Contents survive reset; an edge seen while reset is low must not store.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb[k]) memory[idx[k]] <= wdata[8*k +: 8];
      end
    end
  end
endmodule

module rv_program_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic [31:0] pc
);
  logic [31:0] pc_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_addr <= '0;
    else        pc_addr <= pc_next;
  end

  assign pc = pc_addr;
endmodule

module rv_program_counter_module (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic [31:0] pc
);
  rv_program_counter program_counter (
    .clock(clock), .reset(reset), .pc_next(pc_next), .pc(pc)
  );
endmodule

module rv_registers_bank (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] registers [0:31];

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && (rd != 5'd0)) begin
      registers[rd] <= wdata;
    end
  end

  assign rs1_data = registers[rs1];
  assign rs2_data = registers[rs2];
endmodule

module rv_registers_module (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  rv_registers_bank registers_bank (
    .clock(clock), .reset(reset), .we(we), .rd(rd), .wdata(wdata),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data)
  );
endmodule

module risc_v_cpu_core #(
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] out
);
  logic [31:0] pc, instr, rs1_v, rs2_v, dm_rdata;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_d, wb, dm_addr, out_d, out_q;
  logic [3:0]  dm_strb;
  logic        rd_we, taken;
  logic [6:0]  opcode;
  logic [2:0]  f3;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic alt,
                                      input logic allow_sub);
    case (op)
      3'd0:    alu = (alt && allow_sub) ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'd0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'd0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  rv_instruction_memory #(.BYTES(IMEM_BYTES)) uut_instruction (.addr(pc), .instr(instr));

  rv_data_memory #(.BYTES(DMEM_BYTES)) memory (
    .clock(clock), .reset(reset), .addr(dm_addr), .wstrb(dm_strb),
    .wdata(rs2_v), .rdata(dm_rdata)
  );

  rv_program_counter_module module_program_counter (
    .clock(clock), .reset(reset), .pc_next(pc_d), .pc(pc)
  );

  rv_registers_module module_registers_bank (
    .clock(clock), .reset(reset), .we(rd_we), .rd(instr[11:7]), .wdata(wb),
    .rs1(instr[19:15]), .rs2(instr[24:20]), .rs1_data(rs1_v), .rs2_data(rs2_v)
  );

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'd0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    case (f3)
      3'd0:    taken = (rs1_v == rs2_v);
      3'd1:    taken = (rs1_v != rs2_v);
      3'd4:    taken = ($signed(rs1_v) <  $signed(rs2_v));
      3'd5:    taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6:    taken = (rs1_v <  rs2_v);
      3'd7:    taken = (rs1_v >= rs2_v);
      default: taken = 1'b0;
    endcase
  end

  // Anything not matched below (FENCE, SYSTEM, unknown) falls out as a NOP.
  always_comb begin
    pc_d    = pc + 32'd4;
    rd_we   = 1'b0;
    wb      = '0;
    dm_addr = rs1_v + imm_i;
    dm_strb = 4'b0000;
    case (opcode)
      7'b0110111: begin rd_we = 1'b1; wb = imm_u; end
      7'b0010111: begin rd_we = 1'b1; wb = pc + imm_u; end
      7'b1101111: begin rd_we = 1'b1; wb = pc + 32'd4; pc_d = pc + imm_j; end
      7'b1100111: begin rd_we = 1'b1; wb = pc + 32'd4; pc_d = (rs1_v + imm_i) & ~32'd1; end
      7'b1100011: if (taken) pc_d = pc + imm_b;
      7'b0000011: begin
        rd_we = 1'b1;
        case (f3)
          3'd0:    wb = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
          3'd1:    wb = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
          3'd2:    wb = dm_rdata;
          3'd4:    wb = {24'd0, dm_rdata[7:0]};
          3'd5:    wb = {16'd0, dm_rdata[15:0]};
          default: rd_we = 1'b0;
        endcase
      end
      7'b0100011: begin
        dm_addr = rs1_v + imm_s;
        case (f3)
          3'd0:    dm_strb = 4'b0001;
          3'd1:    dm_strb = 4'b0011;
          3'd2:    dm_strb = 4'b1111;
          default: dm_strb = 4'b0000;
        endcase
      end
      7'b0010011: begin rd_we = 1'b1; wb = alu(f3, rs1_v, imm_i, instr[30], 1'b0); end
      7'b0110011: begin rd_we = 1'b1; wb = alu(f3, rs1_v, rs2_v, instr[30], 1'b1); end
      default: ;
    endcase
    out_d = rd_we ? wb : 32'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;
endmodule

// File: tb/tb_risc_v_cpu_core.sv
// Directed bench for risc_v_cpu_core: small hand-assembled programs, expected
// register/PC/memory values worked out by hand.

module tb_risc_v_cpu_core;
  logic        clock;
  logic        reset;
  logic [31:0] out;

  int pass_count;
  int total_count;

  risc_v_cpu_core #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
    .clock(clock), .reset(reset), .out(out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] halt();
    return enc_b(0, 0, 0, 0);
  endfunction

  function automatic logic [31:0] xreg(int r);
    return dut.module_registers_bank.registers_bank.registers[r];
  endfunction
  function automatic logic [31:0] pc_now();
    return dut.module_program_counter.program_counter.pc_addr;
  endfunction
  function automatic logic [31:0] dword(int a);
    return {dut.memory.memory[a+3], dut.memory.memory[a+2],
            dut.memory.memory[a+1], dut.memory.memory[a]};
  endfunction

  task automatic put(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.uut_instruction.memory[a+k] = w[8*k +: 8];
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 1024; a++) dut.uut_instruction.memory[a] = 8'h00;
  endtask

  // Called at a falling edge: each step retires one instruction and returns
  // at the following falling edge, where outputs are sampled.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic enter_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_imem();
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    pass_count  = 0;
    total_count = 0;
    reset       = 1'b0;

    // Basic ADDI with negative result
    enter_reset();
    put(0, addi(1, 0, 5));
    put(4, addi(2, 1, -7));
    put(8, halt());
    #1;
    check("rst_pc", pc_now(), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_x1", xreg(1), 32'd0);
    release_reset();
    step(1);
    check("t1_x1", xreg(1), 32'd5);
    check("t1_out1", out, 32'd5);
    step(1);
    check("t1_x2", xreg(2), 32'hFFFF_FFFE);
    check("t1_pc", pc_now(), 32'd8);
    check("t1_out2", out, 32'hFFFF_FFFE);
    step(1);
    check("t1_halt_pc", pc_now(), 32'd8);
    check("t1_halt_out", out, 32'd0);

    // Loads and stores of every width
    enter_reset();
    put(0,  enc_u(32'h12345, 3, 7'b0110111));
    put(4,  addi(3, 3, 32'h678));
    put(8,  enc_s(16, 3, 0, 2));
    put(12, enc_i(17, 0, 0, 4, 7'b0000011));
    put(16, enc_i(19, 0, 4, 5, 7'b0000011));
    put(20, enc_s(20, 0, 0, 2));
    put(24, addi(7, 0, -128));
    put(28, enc_s(20, 7, 0, 0));
    put(32, enc_i(20, 0, 0, 8, 7'b0000011));
    put(36, enc_i(20, 0, 4, 9, 7'b0000011));
    put(40, enc_s(22, 3, 0, 1));
    put(44, enc_i(22, 0, 1, 10, 7'b0000011));
    put(48, enc_i(20, 0, 1, 11, 7'b0000011));
    put(52, enc_i(20, 0, 2, 12, 7'b0000011));
    put(56, halt());
    release_reset();
    step(14);
    check("t2_x3", xreg(3), 32'h1234_5678);
    check("t2_mem16", dword(16), 32'h1234_5678);
    check("t2_lb", xreg(4), 32'h0000_0056);
    check("t2_lbu", xreg(5), 32'h0000_0012);
    check("t2_lb_neg", xreg(8), 32'hFFFF_FF80);
    check("t2_lbu_neg", xreg(9), 32'h0000_0080);
    check("t2_lh_after_sh", xreg(10), 32'h0000_5678);
    check("t2_lh_lo", xreg(11), 32'h0000_0080);
    check("t2_lw", xreg(12), 32'h5678_0080);
    check("t2_mem20", dword(20), 32'h5678_0080);
    check("t2_pc", pc_now(), 32'd56);

    // Branches, shifts and register-register ALU ops
    enter_reset();
    put(0,  addi(1, 0, -1));
    put(4,  enc_b(8, 1, 0, 6));
    put(8,  addi(5, 0, 1));
    put(12, enc_b(8, 1, 0, 4));
    put(16, enc_i(32'h404, 1, 5, 2, 7'b0010011));
    put(20, enc_i(4, 1, 5, 3, 7'b0010011));
    put(24, enc_b(8, 0, 1, 5));
    put(28, enc_b(8, 0, 1, 7));
    put(32, addi(5, 0, 2));
    put(36, enc_b(8, 0, 1, 1));
    put(40, addi(5, 0, 3));
    put(44, addi(6, 0, 3));
    put(48, enc_r(0, 6, 1, 1, 7));
    put(52, enc_r(32, 6, 0, 0, 8));
    put(56, enc_r(0, 6, 8, 2, 9));
    put(60, enc_r(0, 6, 8, 3, 10));
    put(64, enc_r(32, 6, 8, 5, 11));
    put(68, enc_r(0, 6, 8, 4, 12));
    put(72, enc_i(32'hF0, 8, 7, 13, 7'b0010011));
    put(76, enc_i(-2, 8, 2, 14, 7'b0010011));
    put(80, enc_i(-1, 6, 3, 15, 7'b0010011));
    put(84, addi(16, 0, 33));
    put(88, enc_r(0, 16, 1, 5, 17));
    put(92, enc_r(0, 16, 6, 6, 18));
    put(96, halt());
    release_reset();
    step(1); check("t3_pc_e1", pc_now(), 32'd4);
    step(1); check("t3_bltu_taken", pc_now(), 32'd12);
    step(1); check("t3_blt_not", pc_now(), 32'd16);
    step(1); check("t3_srai", xreg(2), 32'hFFFF_FFFF);
    step(1); check("t3_srli", xreg(3), 32'h0FFF_FFFF);
    check("t3_bge_at", pc_now(), 32'd24);
    step(1); check("t3_bge_not", pc_now(), 32'd28);
    step(1); check("t3_bgeu_taken", pc_now(), 32'd36);
    step(1); check("t3_bne_taken", pc_now(), 32'd44);
    step(14);
    check("t3_pc_end", pc_now(), 32'd96);
    check("t3_skipped", xreg(5), 32'd0);
    check("t3_sll", xreg(7), 32'hFFFF_FFF8);
    check("t3_sub", xreg(8), 32'hFFFF_FFFD);
    check("t3_slt", xreg(9), 32'd1);
    check("t3_sltu", xreg(10), 32'd0);
    check("t3_sra", xreg(11), 32'hFFFF_FFFF);
    check("t3_xor", xreg(12), 32'hFFFF_FFFE);
    check("t3_andi", xreg(13), 32'h0000_00F0);
    check("t3_slti", xreg(14), 32'd1);
    check("t3_sltiu", xreg(15), 32'd1);
    check("t3_srl_5bit", xreg(17), 32'h7FFF_FFFF);
    check("t3_or", xreg(18), 32'h0000_0023);

    // AUIPC, JAL and JALR with rd == rs1
    enter_reset();
    put(0,  enc_u(1, 5, 7'b0010111));
    put(4,  enc_j(12, 1));
    put(8,  halt());
    put(12, addi(6, 0, 1));
    put(16, enc_i(1, 1, 0, 1, 7'b1100111));
    release_reset();
    step(1);
    check("t4_auipc", xreg(5), 32'h0000_1000);
    step(1);
    check("t4_jal_link", xreg(1), 32'd8);
    check("t4_jal_pc", pc_now(), 32'd16);
    check("t4_jal_out", out, 32'd8);
    step(1);
    check("t4_jalr_pc", pc_now(), 32'd8);
    check("t4_jalr_link", xreg(1), 32'd20);
    step(1);
    check("t4_hold_pc", pc_now(), 32'd8);
    check("t4_skipped", xreg(6), 32'd0);

    // x0 writes discarded; zero word and ECALL behave as NOPs
    enter_reset();
    put(0,  addi(0, 0, 9));
    put(4,  32'h0000_0000);
    put(8,  32'h0000_0073);
    put(12, halt());
    release_reset();
    step(1);
    check("t5_x0", xreg(0), 32'd0);
    check("t5_x0_out", out, 32'd9);
    step(1);
    check("t5_zero_pc", pc_now(), 32'd8);
    check("t5_zero_out", out, 32'd0);
    step(1);
    check("t5_ecall_pc", pc_now(), 32'd12);

    // Reset in the middle of a program
    enter_reset();
    put(0,  addi(1, 0, 32'h5A));
    put(4,  enc_s(40, 1, 0, 0));
    put(8,  addi(2, 1, 1));
    put(12, halt());
    release_reset();
    step(3);
    check("t6_pre_x2", xreg(2), 32'h5B);
    reset = 1'b0;
    #1;
    check("t6_async_pc", pc_now(), 32'd0);
    check("t6_async_x1", xreg(1), 32'd0);
    check("t6_async_x2", xreg(2), 32'd0);
    check("t6_async_out", out, 32'd0);
    check("t6_mem_kept", {24'd0, dut.memory.memory[40]}, 32'h5A);
    step(1);
    check("t6_held_pc", pc_now(), 32'd0);
    reset = 1'b1;
    step(3);
    check("t6_rerun_x1", xreg(1), 32'h5A);
    check("t6_rerun_x2", xreg(2), 32'h5B);
    check("t6_rerun_pc", pc_now(), 32'd12);
    check("t6_rerun_mem", {24'd0, dut.memory.memory[40]}, 32'h5A);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end
endmodule
